// File: rtl/yc_line_sequencer_pkg.sv
// yc_pkg: shared types and constants for the YC line sequencer.
//   line_state_t        per-line FSM state encoding
//   *_THR_HI / *_THR_LO 40-bit phase-increment thresholds that select burst length
//   BURST_LEN_*         burst end counts (samples after hsync fall)
//   carrier_trim()      CHRADD << CHRMUL, zero-extended to 40 bits
package yc_pkg;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_PRE    = 3'd1,
    S_BURST  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VBL    = 3'd4
  } line_state_t;

  localparam logic [39:0] PAL_THR_HI  = 40'd120_000_000_000;
  localparam logic [39:0] PAL_THR_LO  = 40'd74_000_000_000;
  localparam logic [39:0] NTSC_THR_HI = 40'd100_000_000_000;
  localparam logic [39:0] NTSC_THR_LO = 40'd59_000_000_000;

  localparam int unsigned BURST_LEN_SHORT = 140;
  localparam int unsigned BURST_LEN_NOM   = 180;
  localparam int unsigned BURST_LEN_LONG  = 300;

  // Largest result is 31 << 31, which still fits comfortably in 40 bits.
  function automatic logic [39:0] carrier_trim(input logic [4:0] add_v, input logic [4:0] shamt);
    return {35'd0, add_v} << shamt;
  endfunction

endpackage

// File: rtl/yc_line_sequencer_if.sv
// yc_line_sequencer_if: timing-source / encoder-side signals of the line sequencer.
//   Inputs to the sequencer : PAL_EN, PHASE_INC, CHRADD, CHRMUL, MULFLAG, hsync, vsync
//   Outputs of the sequencer: phase_inc_o, burst_en, chroma_en, pal_flip, burst_len
//   master modport = timing source / encoder side, slave modport = sequencer.
interface yc_line_sequencer_if #(
  parameter int CNT_W = 11
);
  logic             PAL_EN;
  logic [39:0]      PHASE_INC;
  logic [4:0]       CHRADD;
  logic [4:0]       CHRMUL;
  logic             MULFLAG;
  logic             hsync;
  logic             vsync;
  logic [39:0]      phase_inc_o;
  logic             burst_en;
  logic             chroma_en;
  logic             pal_flip;
  logic [CNT_W-1:0] burst_len;

  modport master (
    output PAL_EN, PHASE_INC, CHRADD, CHRMUL, MULFLAG, hsync, vsync,
    input  phase_inc_o, burst_en, chroma_en, pal_flip, burst_len
  );

  modport slave (
    input  PAL_EN, PHASE_INC, CHRADD, CHRMUL, MULFLAG, hsync, vsync,
    output phase_inc_o, burst_en, chroma_en, pal_flip, burst_len
  );
endinterface

// File: rtl/yc_line_sequencer_phase_cfg.sv
// yc_phase_cfg: carrier phase-increment latch and burst-length selection.
//   clk, reset          pixel clock, async active-high reset
//   pal_en_i            1 = PAL thresholds, 0 = NTSC thresholds
//   phase_inc_i         nominal subcarrier increment
//   chradd_i/chrmul_i   trim magnitude / shift
//   mulflag_i           0 = add trim, 1 = subtract trim
//   vs_rise_i           vsync rising edge (one clk pulse)
//   phase_inc_o         latched effective increment (field-stable)
//   burst_len_next_o    burst end count for the current inputs (unregistered)
module yc_phase_cfg
  import yc_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pal_en_i,
  input  logic [39:0]      phase_inc_i,
  input  logic [4:0]       chradd_i,
  input  logic [4:0]       chrmul_i,
  input  logic             mulflag_i,
  input  logic             vs_rise_i,
  output logic [39:0]      phase_inc_o,
  output logic [CNT_W-1:0] burst_len_next_o
);

  logic [39:0] trim;
  logic [39:0] phase_d;
  logic [39:0] phase_q;
  logic        load_pending_q;
  logic [39:0] thr_hi;
  logic [39:0] thr_lo;

  assign trim    = carrier_trim(chradd_i, chrmul_i);
  // Modulo-2^40 on purpose: the accumulator downstream wraps anyway.
  assign phase_d = mulflag_i ? (phase_inc_i - trim) : (phase_inc_i + trim);

  // load_pending_q gives one load on the first clk after reset so the
  // encoder has a valid increment before the first vsync arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q        <= '0;
      load_pending_q <= 1'b1;
    end else begin
      load_pending_q <= 1'b0;
      if (load_pending_q || vs_rise_i) begin
        phase_q <= phase_d;
      end
    end
  end

  assign phase_inc_o = phase_q;

  assign thr_hi = pal_en_i ? PAL_THR_HI : NTSC_THR_HI;
  assign thr_lo = pal_en_i ? PAL_THR_LO : NTSC_THR_LO;

  always_comb begin
    burst_len_next_o = CNT_W'(BURST_LEN_NOM);
    if (phase_inc_i > thr_hi) begin
      burst_len_next_o = CNT_W'(BURST_LEN_SHORT);
    end else if (phase_inc_i < thr_lo) begin
      burst_len_next_o = CNT_W'(BURST_LEN_LONG);
    end
  end

endmodule

// File: rtl/yc_line_sequencer.sv
// yc_line_sequencer: per-line burst/chroma window controller for the YC encoder.
//   clk    pixel/encoder clock
//   reset  asynchronous active-high reset
//   bus    yc_line_sequencer_if.slave: video timing, carrier config in;
//          phase_inc_o, burst_en, chroma_en, pal_flip, burst_len out
//
// state    | meaning
// S_SYNC   | hsync high (or waiting for first line); counter held at 0
// S_PRE    | back porch before burst, counting up to BURST_START-1
// S_BURST  | colour burst window, until count == burst_len
// S_ACTIVE | active video, chroma modulation allowed until hsync rise
// S_VBL    | blanked line inside the vertical interval
module yc_line_sequencer
  import yc_pkg::*;
#(
  parameter int CNT_W       = 11,
  parameter int BURST_START = 40,
  parameter int VBL_LINES   = 9
) (
  input  logic              clk,
  input  logic              reset,
  yc_line_sequencer_if.slave bus
);

  localparam int VBL_W = $clog2(VBL_LINES + 1);

  logic             hsync_q;
  logic             vsync_q;
  logic             hs_rise;
  logic             hs_fall;
  logic             vs_rise;

  line_state_t      state_q;
  line_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [VBL_W-1:0] vbl_cnt_q;
  logic [VBL_W-1:0] vbl_cnt_d;
  logic             pal_flip_q;
  logic             pal_flip_d;
  logic             burst_en_q;
  logic             chroma_en_q;
  logic [CNT_W-1:0] burst_len_q;
  logic [CNT_W-1:0] burst_len_next;

  assign hs_rise = bus.hsync & ~hsync_q;
  assign hs_fall = ~bus.hsync & hsync_q;
  assign vs_rise = bus.vsync & ~vsync_q;

  yc_phase_cfg #(
    .CNT_W(CNT_W)
  ) u_phase_cfg (
    .clk              (clk),
    .reset            (reset),
    .pal_en_i         (bus.PAL_EN),
    .phase_inc_i      (bus.PHASE_INC),
    .chradd_i         (bus.CHRADD),
    .chrmul_i         (bus.CHRMUL),
    .mulflag_i        (bus.MULFLAG),
    .vs_rise_i        (vs_rise),
    .phase_inc_o      (bus.phase_inc_o),
    .burst_len_next_o (burst_len_next)
  );

  // A missing hsync must not wrap the counter back into the burst window.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    if (hs_rise) begin
      state_d = S_SYNC;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          cnt_d = '0;
          if (hs_fall) begin
            state_d = (vbl_cnt_q != '0) ? S_VBL : S_PRE;
          end
        end
        S_PRE: begin
          if (cnt_q == CNT_W'(BURST_START - 1)) begin
            state_d = S_BURST;
          end
        end
        S_BURST: begin
          if (cnt_q == burst_len_q) begin
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: state_d = S_ACTIVE;
        S_VBL:    state_d = S_VBL;
        default: begin
          state_d = S_SYNC;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // vsync load wins over a coincident hsync decrement so the field always
  // gets the full blanking count.
  always_comb begin
    vbl_cnt_d = vbl_cnt_q;
    if (vs_rise) begin
      vbl_cnt_d = VBL_W'(VBL_LINES);
    end else if (hs_rise && (vbl_cnt_q != '0)) begin
      vbl_cnt_d = vbl_cnt_q - VBL_W'(1);
    end
  end

  always_comb begin
    pal_flip_d = 1'b0;
    if (bus.PAL_EN) begin
      pal_flip_d = hs_rise ? ~pal_flip_q : pal_flip_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      vbl_cnt_q   <= '0;
      pal_flip_q  <= 1'b0;
      burst_en_q  <= 1'b0;
      chroma_en_q <= 1'b0;
      burst_len_q <= CNT_W'(BURST_LEN_NOM);
    end else begin
      hsync_q     <= bus.hsync;
      vsync_q     <= bus.vsync;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vbl_cnt_q   <= vbl_cnt_d;
      pal_flip_q  <= pal_flip_d;
      // Outputs come from the next state so they move with the state register.
      burst_en_q  <= (state_d == S_BURST);
      chroma_en_q <= (state_d == S_ACTIVE);
      // Burst length only changes at line start, never inside a line.
      if (hs_rise) begin
        burst_len_q <= burst_len_next;
      end
    end
  end

  assign bus.burst_en  = burst_en_q;
  assign bus.chroma_en = chroma_en_q;
  assign bus.pal_flip  = pal_flip_q;
  assign bus.burst_len = burst_len_q;

endmodule

// File: tb/tb_yc_line_sequencer.sv
module tb_yc_line_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  yc_line_sequencer_if #(.CNT_W(11)) ifc ();

  yc_line_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_cmp = 0;
  int n_err = 0;

  int b_first, b_last, b_cnt, c_first, c_last, c_cnt, s0_c;
  logic        flip_s;
  logic [10:0] blen_s;
  logic        flip_exp;
  int          seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One line: hsync high for hi clks, then low up to total clks.
  // Positions are recorded relative to the first clk with hsync low.
  // vs_step >= 0 gives a 3-clk vsync pulse starting at that step.
  task automatic run_line(input int hi, input int total, input int vs_step);
    int rel;
    b_first = -1; b_last = -1; b_cnt = 0;
    c_first = -1; c_last = -1; c_cnt = 0;
    s0_c = 0;
    for (int i = 0; i < total; i++) begin
      ifc.hsync = (i < hi);
      if (vs_step >= 0 && i == vs_step)     ifc.vsync = 1'b1;
      if (vs_step >= 0 && i == vs_step + 3) ifc.vsync = 1'b0;
      tick();
      rel = i - hi;
      if (i == 0) s0_c = int'(ifc.chroma_en) + int'(ifc.burst_en);
      if (ifc.burst_en) begin
        if (b_first < 0) b_first = rel;
        b_last = rel;
        b_cnt++;
      end
      if (ifc.chroma_en) begin
        if (c_first < 0) c_first = rel;
        c_last = rel;
        c_cnt++;
      end
    end
    flip_s = ifc.pal_flip;
    blen_s = ifc.burst_len;
  endtask

  initial begin
    reset         = 1'b1;
    ifc.PAL_EN    = 1'b0;
    ifc.PHASE_INC = 40'd80_000_000_000;
    ifc.CHRADD    = 5'd0;
    ifc.CHRMUL    = 5'd0;
    ifc.MULFLAG   = 1'b0;
    ifc.hsync     = 1'b0;
    ifc.vsync     = 1'b0;
    tick(); tick(); tick();

    chk("rst_burst_en",  ifc.burst_en, 0);
    chk("rst_chroma_en", ifc.chroma_en, 0);
    chk("rst_pal_flip",  ifc.pal_flip, 0);
    chk("rst_burst_len", ifc.burst_len, 180);
    chk("rst_phase",     ifc.phase_inc_o, 0);

    reset = 1'b0;
    tick();
    chk("phase_first_load", ifc.phase_inc_o, 40'd80_000_000_000);

    // NTSC, 80e9 -> burst_len 180, 1716-clk lines with 100-clk hsync
    run_line(100, 1716, -1);
    chk("ntsc1_b_first", b_first, 40);
    chk("ntsc1_b_last",  b_last, 180);
    chk("ntsc1_b_cnt",   b_cnt, 141);
    chk("ntsc1_c_first", c_first, 181);
    chk("ntsc1_c_last",  c_last, 1615);
    chk("ntsc1_c_cnt",   c_cnt, 1435);
    run_line(100, 1716, -1);
    chk("ntsc2_rise_clears", s0_c, 0);
    chk("ntsc2_b_first", b_first, 40);
    chk("ntsc2_b_cnt",   b_cnt, 141);
    chk("ntsc2_c_cnt",   c_cnt, 1435);
    chk("ntsc2_blen",    blen_s, 180);

    // Trim only takes effect at vsync rise
    ifc.PHASE_INC = 40'd100_000_000_000;
    ifc.CHRADD    = 5'd3;
    ifc.CHRMUL    = 5'd4;
    ifc.MULFLAG   = 1'b0;
    tick(); tick();
    chk("trim_held", ifc.phase_inc_o, 40'd80_000_000_000);

    // vsync rising while hsync is high: 9 blanked lines, then normal
    run_line(20, 400, 5);
    chk("trim_add", ifc.phase_inc_o, 40'd100_000_000_048);
    chk("vbl1_line1_b", b_cnt, 0);
    chk("vbl1_line1_c", c_cnt, 0);
    for (int k = 2; k <= 9; k++) begin
      run_line(20, 400, -1);
      chk($sformatf("vbl1_line%0d_bc", k), b_cnt + c_cnt, 0);
    end
    run_line(20, 400, -1);
    chk("vbl1_line10_b_first", b_first, 40);
    chk("vbl1_line10_b_cnt",   b_cnt, 141);
    chk("vbl1_line10_c_cnt",   c_cnt, 199);

    ifc.MULFLAG = 1'b1;
    tick(); tick();
    chk("trim_sub_held", ifc.phase_inc_o, 40'd100_000_000_048);

    // vsync and hsync rising in the same clk: still 9 blanked lines
    run_line(20, 400, 0);
    chk("trim_sub", ifc.phase_inc_o, 40'd99_999_999_952);
    chk("vbl2_line1_bc", b_cnt + c_cnt, 0);
    for (int k = 2; k <= 9; k++) begin
      run_line(20, 400, -1);
      chk($sformatf("vbl2_line%0d_bc", k), b_cnt + c_cnt, 0);
    end
    run_line(20, 400, -1);
    chk("vbl2_line10_b_first", b_first, 40);
    chk("vbl2_line10_b_cnt",   b_cnt, 141);

    // PAL, 130e9 -> burst_len 140, pal_flip toggles every line
    ifc.PAL_EN    = 1'b1;
    ifc.PHASE_INC = 40'd130_000_000_000;
    tick();
    chk("pal_flip_pre", ifc.pal_flip, 0);
    flip_exp = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      run_line(20, 400, -1);
      flip_exp = ~flip_exp;
      chk($sformatf("pal_flip_line%0d", k), flip_s, flip_exp);
      chk($sformatf("pal_blen_line%0d", k), blen_s, 140);
    end
    chk("pal_b_last",  b_last, 140);
    chk("pal_b_cnt",   b_cnt, 101);
    chk("pal_c_first", c_first, 141);

    run_line(20, 400, -1);
    chk("pal_flip_line5", flip_s, 1);

    // PAL_EN falls mid-line: flip cleared next clk; burst_len held till line start
    ifc.PAL_EN    = 1'b0;
    ifc.PHASE_INC = 40'd50_000_000_000;
    tick();
    chk("pal_off_flip", ifc.pal_flip, 0);
    chk("blen_not_midline", ifc.burst_len, 140);
    run_line(20, 400, -1);
    chk("pal_off_flip_stays", flip_s, 0);
    chk("ntsc_long_blen",   blen_s, 300);
    chk("ntsc_long_b_last", b_last, 300);
    chk("ntsc_long_c_first", c_first, 301);

    // Reset during burst
    for (int i = 0; i < 20; i++) begin
      ifc.hsync = 1'b1;
      tick();
    end
    ifc.hsync = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick();
      if (ifc.burst_en) seen = 1;
    end
    chk("rstb_burst_reached", seen, 1);
    reset = 1'b1;
    #1;
    chk("rstb_burst_off_now", ifc.burst_en, 0);
    chk("rstb_blen_reset", ifc.burst_len, 180);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rstb_phase_reload", ifc.phase_inc_o, 40'd49_999_999_952);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifc.burst_en || ifc.chroma_en) seen++;
    end
    chk("rstb_quiet_until_rise", seen, 0);
    run_line(20, 400, -1);
    chk("rstb_next_b_first", b_first, 40);
    chk("rstb_next_b_last",  b_last, 300);
    chk("rstb_next_c_first", c_first, 301);

    // Wrap-around of the 40-bit result, both directions
    ifc.PHASE_INC = 40'hFF_FFFF_FFFF;
    ifc.CHRADD    = 5'd31;
    ifc.CHRMUL    = 5'd31;
    ifc.MULFLAG   = 1'b0;
    ifc.vsync     = 1'b1;
    tick();
    chk("trim_max_wrap_add", ifc.phase_inc_o, 40'd66_571_993_087);
    ifc.vsync     = 1'b0;
    ifc.PHASE_INC = 40'd0;
    ifc.CHRADD    = 5'd1;
    ifc.CHRMUL    = 5'd0;
    ifc.MULFLAG   = 1'b1;
    tick();
    ifc.vsync = 1'b1;
    tick();
    chk("trim_wrap_sub", ifc.phase_inc_o, 40'hFF_FFFF_FFFF);
    ifc.vsync = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
